maf_sign_pipe: RTL and testbench

- Pipelined, multi-lane sign-resolution unit for the general-precision multiply-add datapath.
- Per lane, computes the final result sign from the operand signs, the operation variant (FMA/FMS/FNMA/FNMS), the exponent-compare and mantissa-adder outcomes, the rounding mode and special-operand flags.
- Carries the result through a stallable valid/ready pipeline whose depth matches the mantissa path, so sign and magnitude arrive at the packer together.

---
 rtl/maf_sign_pipe_if.sv | 31 +++
 rtl/maf_sign_pipe.sv | 48 ++++
 tb/tb_maf_sign_pipe.sv | 128 ++++++++++++
 3 files changed

// File: rtl/maf_sign_pipe_if.sv
// maf_sign_pipe_if: beat handshake plus per-lane sign-resolution operands and results
interface maf_sign_pipe_if #(parameter int LANES = 1);
  logic in_valid;
  logic in_ready;
  logic [1:0] op;
  logic [1:0] rm;
  logic [LANES-1:0] sign_a;
  logic [LANES-1:0] sign_b;
  logic [LANES-1:0] sign_c;
  logic [LANES-1:0] comp_exp;
  logic [LANES-1:0] sign_add;
  logic [LANES-1:0] zero_res;
  logic [LANES-1:0] prod_inf;
  logic [LANES-1:0] c_inf;
  logic [LANES-1:0] nan_in;
  logic out_valid;
  logic out_ready;
  logic [LANES-1:0] sign_res;
  logic [LANES-1:0] nan_out;
  logic [LANES-1:0] invalid;
  modport master (
    output in_valid, op, rm, sign_a, sign_b, sign_c, comp_exp, sign_add,
           zero_res, prod_inf, c_inf, nan_in, out_ready,
    input  in_ready, out_valid, sign_res, nan_out, invalid
  );
  modport slave (
    input  in_valid, op, rm, sign_a, sign_b, sign_c, comp_exp, sign_add,
           zero_res, prod_inf, c_inf, nan_in, out_ready,
    output in_ready, out_valid, sign_res, nan_out, invalid
  );
endinterface

// File: rtl/maf_sign_pipe.sv
// maf_sign_pipe: per-lane multiply-add result sign resolution carried through a stallable delay pipe
module maf_sign_pipe #(
  parameter int LANES  = 1,
  parameter int STAGES = 2
) (
  input logic clk,
  input logic rst,
  maf_sign_pipe_if.slave bus
);
  logic [LANES-1:0] sp, sc, es, clash, sgn, nan, inv;
  logic [3*LANES-1:0] pl [STAGES];
  logic [STAGES-1:0] vld;
  logic adv;
  assign sp    = bus.sign_a ^ bus.sign_b ^ {LANES{bus.op[1]}};
  assign sc    = bus.sign_c ^ {LANES{bus.op[0]}};
  assign es    = sp ^ sc;
  assign clash = bus.prod_inf & bus.c_inf & es;
  assign nan   = bus.nan_in | clash;
  assign inv   = (bus.nan_in & bus.prod_inf) | (~bus.nan_in & clash);
  // resolve each lane's sign by special-case priority, then the adder outcome
  always_comb begin
    sgn = '0;
    for (int l = 0; l < LANES; l++)
      sgn[l] = nan[l]           ? 1'b0 :
               bus.prod_inf[l]  ? sp[l] :
               bus.c_inf[l]     ? sc[l] :
               bus.zero_res[l]  ? (es[l] ? (bus.rm == 2'b11) : sc[l]) :
               (es[l] & (bus.comp_exp[l] | bus.sign_add[l])) ? sp[l] : sc[l];
  end
  assign adv           = bus.out_ready | ~vld[STAGES-1];
  assign bus.in_ready  = adv;
  assign bus.out_valid = vld[STAGES-1];
  assign {bus.invalid, bus.nan_out, bus.sign_res} = pl[STAGES-1];
  // whole pipe shifts together when the tail can drain, bubbles carry a zero payload
  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= '0;
      for (int i = 0; i < STAGES; i++) pl[i] <= '0;
    end else if (adv) begin
      vld[0] <= bus.in_valid;
      pl[0]  <= bus.in_valid ? {inv, nan, sgn} : '0;
      for (int i = 1; i < STAGES; i++) begin
        vld[i] <= vld[i-1];
        pl[i]  <= pl[i-1];
      end
    end
  end
endmodule

// File: tb/tb_maf_sign_pipe.sv
// tb_maf_sign_pipe: directed checks of sign resolution, latency, back-pressure and reset
module tb_maf_sign_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int err = 0;
  always #5 clk = ~clk;
  maf_sign_pipe_if #(.LANES(1)) b1 ();
  maf_sign_pipe_if #(.LANES(4)) b4 ();
  maf_sign_pipe #(.LANES(1), .STAGES(2)) u1 (.clk(clk), .rst(rst), .bus(b1.slave));
  maf_sign_pipe #(.LANES(4), .STAGES(3)) u4 (.clk(clk), .rst(rst), .bus(b4.slave));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n++;
    assert (obs === exp) else begin
      err++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  // f = {a,b,c,comp_exp,sign_add,zero_res,prod_inf,c_inf,nan_in}, e = {sign,nan,invalid}
  task automatic v1(input string tag, input logic [1:0] op, input logic [1:0] rm,
                    input logic [8:0] f, input logic [2:0] e);
    b1.op = op;
    b1.rm = rm;
    {b1.sign_a, b1.sign_b, b1.sign_c, b1.comp_exp, b1.sign_add, b1.zero_res,
     b1.prod_inf, b1.c_inf, b1.nan_in} = f;
    b1.in_valid = 1'b1;
    @(posedge clk);
    #1;
    b1.in_valid = 1'b0;
    b1.op = ~op;
    b1.rm = ~rm;
    @(negedge clk);
    chk({tag, "_lat"}, {15'd0, b1.out_valid}, 16'd0);
    @(negedge clk);
    chk(tag, {12'd0, b1.out_valid, b1.sign_res, b1.nan_out, b1.invalid}, {12'd0, 1'b1, e});
  endtask
  logic [3:0] sa_t [6] = '{4'h3, 4'h5, 4'hA, 4'hC, 4'hF, 4'h6};
  logic [3:0] ni_t [6] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
  logic [3:0] pi_t [6] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
  logic [3:0] s_t  [6] = '{4'h3, 4'h5, 4'h2, 4'hC, 4'hE, 4'h6};
  logic [3:0] n_t  [6] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h1, 4'h0};
  logic [3:0] i_t  [6] = '{4'h0, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0};
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int wi, ri;
    logic acc, fire;
    {b1.in_valid, b1.op, b1.rm, b1.sign_a, b1.sign_b, b1.sign_c, b1.comp_exp, b1.sign_add,
     b1.zero_res, b1.prod_inf, b1.c_inf, b1.nan_in} = '0;
    {b4.in_valid, b4.op, b4.rm, b4.sign_a, b4.sign_b, b4.sign_c, b4.comp_exp, b4.sign_add,
     b4.zero_res, b4.prod_inf, b4.c_inf, b4.nan_in} = '0;
    b1.out_ready = 1'b1;
    b4.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst1", {12'd0, b1.out_valid, b1.sign_res, b1.nan_out, b1.invalid}, 16'd0);
    chk("rst1_rdy", {15'd0, b1.in_ready}, 16'd1);
    chk("rst4", {3'd0, b4.out_valid, b4.sign_res, b4.nan_out, b4.invalid}, 16'd0);
    rst = 1'b0;
    v1("fma_ce",    2'd0, 2'd0, 9'b100_1_0_0_0_0_0, 3'b100);
    v1("fms",       2'd1, 2'd0, 9'b100_1_0_0_0_0_0, 3'b100);
    v1("fnma",      2'd2, 2'd0, 9'b100_1_0_0_0_0_0, 3'b000);
    v1("fnms_sc",   2'd3, 2'd0, 9'b100_0_0_0_0_0_0, 3'b100);
    v1("fnms_sp",   2'd3, 2'd0, 9'b100_0_1_0_0_0_0, 3'b000);
    v1("zero_rne",  2'd0, 2'd0, 9'b001_0_0_1_0_0_0, 3'b000);
    v1("zero_rdn",  2'd0, 2'd3, 9'b001_0_0_1_0_0_0, 3'b100);
    v1("zero_rup",  2'd0, 2'd2, 9'b001_0_0_1_0_0_0, 3'b000);
    v1("zero_add",  2'd0, 2'd0, 9'b101_0_0_1_0_0_0, 3'b100);
    v1("inf_clash", 2'd0, 2'd0, 9'b001_0_0_0_1_1_0, 3'b011);
    v1("inf_same",  2'd0, 2'd0, 9'b101_0_0_0_1_1_0, 3'b100);
    v1("nan",       2'd0, 2'd0, 9'b100_0_0_0_0_0_1, 3'b010);
    v1("nan_inf0",  2'd0, 2'd0, 9'b100_0_0_0_1_0_1, 3'b011);
    v1("pinf",      2'd0, 2'd0, 9'b100_0_0_1_1_0_0, 3'b100);
    v1("cinf",      2'd0, 2'd0, 9'b100_0_0_0_0_1_0, 3'b000);
    b4.comp_exp = 4'hF;
    wi = 0;
    ri = 0;
    for (int cyc = 0; cyc < 40 && ri < 6; cyc++) begin
      if (b4.out_valid)
        chk("bp_out", {4'd0, b4.invalid, b4.nan_out, b4.sign_res}, {4'd0, i_t[ri], n_t[ri], s_t[ri]});
      b4.out_ready = !(cyc >= 4 && cyc <= 7);
      b4.in_valid = (wi < 6);
      if (wi < 6) begin
        b4.sign_a = sa_t[wi];
        b4.nan_in = ni_t[wi];
        b4.prod_inf = pi_t[wi];
      end
      #1;
      chk("bp_rdy", {15'd0, b4.in_ready}, {15'd0, !(b4.out_valid && !b4.out_ready)});
      if (cyc == 5) chk("bp_stall", {14'd0, b4.out_valid, b4.in_ready}, 16'd2);
      acc = b4.in_valid && b4.in_ready;
      fire = b4.out_valid && b4.out_ready;
      @(negedge clk);
      wi += int'(acc);
      ri += int'(fire);
    end
    chk("bp_in", 16'(wi), 16'd6);
    chk("bp_done", 16'(ri), 16'd6);
    b4.in_valid = 1'b0;
    b4.out_ready = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("bp_tail", {15'd0, b4.out_valid}, 16'd0);
    end
    for (int k = 0; k < 3; k++) begin
      b4.in_valid = 1'b1;
      b4.sign_a = 4'hF;
      b4.nan_in = 4'h0;
      b4.prod_inf = 4'h0;
      @(negedge clk);
    end
    chk("pre_rst", {15'd0, b4.out_valid}, 16'd1);
    rst = 1'b1;
    b4.in_valid = 1'b0;
    @(negedge clk);
    chk("mid_rst", {3'd0, b4.out_valid, b4.sign_res, b4.nan_out, b4.invalid}, 16'd0);
    chk("mid_rst_rdy", {15'd0, b4.in_ready}, 16'd1);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst", {15'd0, b4.out_valid}, 16'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n, err);
    $finish;
  end
endmodule
